spi_master_tx: RTL and testbench

SPI master transmit engine that sits directly upstream of the SPI receive shift register. It accepts one parallel word over a valid/ready handshake and serialises it onto MOSI, LSB first, matching the receiver's bit-0-first capture order. It generates SCLK for the configured clock polarity and phase, and frames each word with an active-low slave select. It pulses DONE when the frame completes.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_master_tx.sv | 142 ++++++++++++++
 tb/tb_spi_master_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transmit engine.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold
  } spi_state_e;

  localparam int unsigned DefaultDPack = 8;

  // SPI modes as {C_POL, C_PH}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while enabled and pulses TICK at terminal count.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  input  logic EN,
  output logic TICK
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] Terminal = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign TICK = EN && (cnt_q == Terminal);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (CLR) begin
      cnt_q <= '0;
    end else if (EN) begin
      cnt_q <= TICK ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI master transmitter: serialises one word LSB first with configurable CPOL/CPHA,
// frames it with active-low SS_N and pulses DONE at the end of the frame.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int unsigned D_PACK  = DefaultDPack,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [D_PACK-1:0] PAR_IN,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  input  logic              C_POL,
  input  logic              C_PH,
  output logic              SCLK,
  output logic              MOSI,
  output logic              SS_N,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned EdgeW = $clog2(2 * D_PACK + 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * D_PACK);

  spi_state_e        state_q, state_d;
  logic [D_PACK-1:0] shreg_q, shreg_d;
  logic [EdgeW-1:0]  edge_cnt_q, edge_cnt_d, edge_nxt;
  logic              cfg_pol_q, cfg_pol_d;
  logic              cfg_ph_q, cfg_ph_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .CLK  (CLK),
    .RST_N(RST_N),
    .CLR  (state_q == StIdle),
    .EN   (state_q != StIdle),
    .TICK (tick)
  );

  assign edge_nxt = edge_cnt_q + EdgeW'(1);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    edge_cnt_d = edge_cnt_q;
    cfg_pol_d  = cfg_pol_q;
    cfg_ph_d   = cfg_ph_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        sclk_d = C_POL;
        mosi_d = 1'b0;
        if (LOAD_VALID) begin
          shreg_d    = PAR_IN;
          cfg_pol_d  = C_POL;
          cfg_ph_d   = C_PH;
          ss_n_d     = 1'b0;
          busy_d     = 1'b1;
          edge_cnt_d = '0;
          mosi_d     = C_PH ? 1'b0 : PAR_IN[0];
          state_d    = StShift;
        end
      end
      StShift: begin
        if (tick) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_nxt;
          // CPHA=0 presents bit 0 at accept, so advance on even edges except the final one;
          // CPHA=1 presents each bit on the odd (leading) edge.
          if (!cfg_ph_q && !edge_nxt[0] && (edge_nxt != LastEdge)) begin
            mosi_d  = shreg_q[1];
            shreg_d = shreg_q >> 1;
          end else if (cfg_ph_q && edge_nxt[0]) begin
            mosi_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
          if (edge_nxt == LastEdge) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        sclk_d = cfg_pol_q;
        if (tick) begin
          ss_n_d  = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      edge_cnt_q <= '0;
      cfg_pol_q  <= 1'b0;
      cfg_ph_q   <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      edge_cnt_q <= edge_cnt_d;
      cfg_pol_q  <= cfg_pol_d;
      cfg_ph_q   <= cfg_ph_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign LOAD_READY = (state_q == StIdle);
  assign SCLK       = sclk_q;
  assign MOSI       = mosi_q;
  assign SS_N       = ss_n_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (8-bit/div 4 and 4-bit/div 1) checked cycle by cycle
// against a frame-timing model plus a bench-side SIPO receiver.
module tb_spi_master_tx;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;

  logic [7:0] a_par;
  logic       a_valid, a_pol, a_ph;
  logic       a_ready, a_sclk, a_mosi, a_ss_n, a_busy, a_done;
  logic [3:0] b_par;
  logic       b_valid, b_pol, b_ph;
  logic       b_ready, b_sclk, b_mosi, b_ss_n, b_busy, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  spi_master_tx #(.D_PACK(8), .CLK_DIV(4)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .PAR_IN(a_par), .LOAD_VALID(a_valid), .LOAD_READY(a_ready),
    .C_POL(a_pol), .C_PH(a_ph), .SCLK(a_sclk), .MOSI(a_mosi), .SS_N(a_ss_n), .BUSY(a_busy),
    .DONE(a_done)
  );

  spi_master_tx #(.D_PACK(4), .CLK_DIV(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .PAR_IN(b_par), .LOAD_VALID(b_valid), .LOAD_READY(b_ready),
    .C_POL(b_pol), .C_PH(b_ph), .SCLK(b_sclk), .MOSI(b_mosi), .SS_N(b_ss_n), .BUSY(b_busy),
    .DONE(b_done)
  );

  // Output vector order: {SCLK, MOSI, SS_N, BUSY, DONE, LOAD_READY}
  function automatic logic [5:0] obs(input bit sel);
    return sel ? {b_sclk, b_mosi, b_ss_n, b_busy, b_done, b_ready}
               : {a_sclk, a_mosi, a_ss_n, a_busy, a_done, a_ready};
  endfunction

  // t = CLK edges since the accept edge
  function automatic logic [5:0] model(input logic [7:0] w, input bit pol, input bit ph,
                                       input int d, input int div, input int t);
    int k, idx;
    logic mosi;
    if (t >= (2 * d + 1) * div) return {pol, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    k = t / div;
    if (k > 2 * d) k = 2 * d;
    if (!ph) begin
      idx = k / 2;
      if (idx > d - 1) idx = d - 1;
      mosi = w[idx];
    end else if (k == 0) begin
      mosi = 1'b0;
    end else begin
      mosi = w[(k - 1) / 2];
    end
    return {pol ^ k[0], mosi, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic check(input string tag, input int t, input logic [5:0] o, input logic [5:0] e);
    n_tests++;
    assert (o === e)
    else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, o, e);
    end
  endtask

  task automatic set_in(input bit sel, input logic [7:0] par, input bit valid, input bit pol,
                        input bit ph);
    if (sel) begin
      b_par = par[3:0]; b_valid = valid; b_pol = pol; b_ph = ph;
    end else begin
      a_par = par; a_valid = valid; a_pol = pol; a_ph = ph;
    end
  endtask

  // Present the word with LOAD_VALID low for one cycle, check idle SCLK level, then raise valid.
  task automatic idle_setup(input bit sel, input logic [7:0] w, input logic [1:0] mode);
    set_in(sel, w, 1'b0, mode[1], mode[0]);
    @(posedge CLK); #1;
    check("idle", -1, obs(sel), {mode[1], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    set_in(sel, w, 1'b1, mode[1], mode[0]);
  endtask

  // Inputs are already presented; the next edge is the accept edge.
  task automatic frame(input bit sel, input logic [7:0] w, input logic [1:0] mode,
                       input bit hold_valid, input int abort_t, input string tag);
    int d, div, end_t, nb;
    bit pol, ph, prev, lead;
    logic [7:0] cap, ew;
    logic [5:0] o;
    d = sel ? 4 : 8;
    div = sel ? 1 : 4;
    end_t = (2 * d + 1) * div;
    pol = mode[1];
    ph = mode[0];
    ew = sel ? {4'h0, w[3:0]} : w;
    cap = '0;
    nb = 0;
    prev = pol;
    @(posedge CLK); #1;
    for (int t = 0; t <= end_t; t++) begin
      if (t > 0) begin
        @(posedge CLK); #1;
      end
      if (t == abort_t) begin
        RST_N = 1'b0;
        #1;
        check({tag, "_rst_async"}, t, obs(sel), 6'b001001);
        repeat (2) begin
          @(posedge CLK); #1;
          check({tag, "_rst_hold"}, t, obs(sel), 6'b001001);
        end
        set_in(sel, w, 1'b0, 1'b1, 1'b0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check({tag, "_rst_release"}, t, obs(sel), 6'b101001);
        return;
      end
      o = obs(sel);
      check(tag, t, o, model(ew, pol, ph, d, div, t));
      if (t > 0 && o[5] != prev) begin
        lead = (prev == pol);
        if (lead != ph && nb < 8) begin
          cap[nb] = o[4];
          nb++;
        end
      end
      prev = o[5];
      // Scramble ignored inputs while busy; restore the latched mode before the frame ends.
      if (t < end_t - 1)
        set_in(sel, 8'($urandom), hold_valid, 1'($urandom), 1'($urandom));
      else
        set_in(sel, w, hold_valid, pol, ph);
    end
    n_tests++;
    assert (nb == d && cap === ew)
    else begin
      n_fail++;
      $error("FAIL %s_sipo observed=%h/%0d bits expected=%h/%0d bits", tag, cap, nb, ew, d);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [1:0] m;
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    check("reset_a", 0, obs(1'b0), 6'b001001);
    check("reset_b", 0, obs(1'b1), 6'b001001);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    idle_setup(1'b0, 8'hA5, spi_pkg::MODE0);
    frame(1'b0, 8'hA5, spi_pkg::MODE0, 1'b0, -1, "mode0_a5");

    idle_setup(1'b0, 8'h3C, spi_pkg::MODE1);
    frame(1'b0, 8'h3C, spi_pkg::MODE1, 1'b0, -1, "mode1_3c");
    idle_setup(1'b0, 8'h3C, spi_pkg::MODE2);
    frame(1'b0, 8'h3C, spi_pkg::MODE2, 1'b0, -1, "mode2_3c");
    idle_setup(1'b0, 8'h3C, spi_pkg::MODE3);
    frame(1'b0, 8'h3C, spi_pkg::MODE3, 1'b0, -1, "mode3_3c");

    idle_setup(1'b0, 8'h01, spi_pkg::MODE0);
    frame(1'b0, 8'h01, spi_pkg::MODE0, 1'b1, -1, "b2b_01");
    set_in(1'b0, 8'hFE, 1'b1, 1'b1, 1'b1);
    frame(1'b0, 8'hFE, spi_pkg::MODE3, 1'b0, -1, "b2b_fe");

    idle_setup(1'b0, 8'hC3, spi_pkg::MODE2);
    frame(1'b0, 8'hC3, spi_pkg::MODE2, 1'b0, 20, "abort");
    idle_setup(1'b0, 8'h5A, spi_pkg::MODE0);
    frame(1'b0, 8'h5A, spi_pkg::MODE0, 1'b0, -1, "after_rst_5a");

    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom);
      m = 2'($urandom);
      idle_setup(1'b0, w, m);
      frame(1'b0, w, m, 1'b0, -1, "rand_a");
    end

    idle_setup(1'b1, 8'h09, spi_pkg::MODE0);
    frame(1'b1, 8'h09, spi_pkg::MODE0, 1'b0, -1, "div1_9");
    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom);
      m = 2'($urandom);
      idle_setup(1'b1, w, m);
      frame(1'b1, w, m, 1'b0, -1, "rand_b");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
